flapjack_periph_bus: RTL and testbench

//  Parametrised peripheral interconnect between flapjack_core and NUM_PERIPH slave peripherals.
//  It generalises the fixed point-to-point textmode/sdcard links into one address-decoded request/ack fabric.

---
 rtl/flapjack_bus_pkg.sv | 18 +
 rtl/flapjack_bus_timeout.sv | 34 +++
 rtl/flapjack_periph_bus.sv | 144 ++++++++++++++
 tb/tb_flapjack_periph_bus.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flapjack_bus_pkg.sv
// Shared types and constants for the flapjack peripheral bus and the bus peripherals
// that hang off it.
package flapjack_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } bus_state_t;

   localparam int STAT_W = 8;

   // Width of the peripheral-local offset once the select bits are stripped off.
   function automatic int offs_w(input int addr_w, input int sel_w);
      return addr_w - sel_w;
   endfunction

endpackage

// File: rtl/flapjack_bus_timeout.sv
// Loadable up-counter with clear and enable.
// expire is high while the count sits at TIMEOUT-1.
module flapjack_bus_timeout #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT)
) (
   input  logic             clk_sys,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             expire
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   // Counting stops at LAST so that a caller which ignores expire cannot wrap around.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (en && cnt != LAST)
         cnt <= cnt + 1'b1;
   end

   assign expire = (cnt == LAST);

endmodule

// File: rtl/flapjack_periph_bus.sv
// Address-decoded request/ack fabric between flapjack_core and NUM_PERIPH peripherals.
// Only one transaction is outstanding at a time; each access has a timeout and timeouts are counted.
module flapjack_periph_bus
   import flapjack_bus_pkg::*;
#(
   parameter int NUM_PERIPH = 4,
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int SEL_W      = 2,
   parameter int TIMEOUT    = 255
) (
   input  logic                         clk_sys,
   input  logic                         rst_n,
   input  logic                         h_req,
   input  logic                         h_we,
   input  logic [ADDR_W-1:0]            h_addr,
   input  logic [DATA_W-1:0]            h_wdata,
   output logic                         h_ready,
   output logic                         h_rvalid,
   output logic [DATA_W-1:0]            h_rdata,
   output logic                         h_err,
   output logic [NUM_PERIPH-1:0]        p_req,
   output logic                         p_we,
   output logic [ADDR_W-SEL_W-1:0]      p_addr,
   output logic [DATA_W-1:0]            p_wdata,
   input  logic [NUM_PERIPH-1:0]        p_ack,
   input  logic [NUM_PERIPH*DATA_W-1:0] p_rdata,
   output logic [STAT_W-1:0]            stat_timeouts,
   output bus_state_t                   dbg_state
);

   localparam int OFFS_W = offs_w(ADDR_W, SEL_W);
   localparam logic [NUM_PERIPH-1:0] PORT0 = NUM_PERIPH'(1);
   localparam logic [SEL_W:0]        NUM_P = (SEL_W + 1)'(NUM_PERIPH);

   if (NUM_PERIPH < 1 || NUM_PERIPH > 2 ** SEL_W) begin : g_bad_num_periph
      $error("flapjack_periph_bus: NUM_PERIPH must be in 1 .. 2**SEL_W");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("flapjack_periph_bus: TIMEOUT must be at least 1");
   end

   bus_state_t        state;
   logic [SEL_W-1:0]  h_sel;
   logic [SEL_W-1:0]  sel_q;
   logic              sel_ok;
   logic              accept;
   logic              ack_hit;
   logic              tmo_expire;
   logic [DATA_W-1:0] rd_slice;

   // Host handshake: a request transfers on any cycle where h_req and h_ready are both high;
   // h_req is held until then. Every accepted request ends in exactly one h_rvalid pulse,
   // with h_rdata/h_err valid in that cycle. Peripheral side: p_req stays high until p_ack.
   assign accept = h_req & h_ready;
   assign h_sel  = h_addr[ADDR_W-1 -: SEL_W];
   assign sel_ok = ({1'b0, h_sel} < NUM_P);

   // p_req is non-zero only in ACCESS and only on the selected port, so this
   // masks out stray acks without decoding the state again.
   assign ack_hit  = |(p_ack & p_req);
   assign rd_slice = p_rdata[sel_q*DATA_W +: DATA_W];

   flapjack_bus_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk_sys  (clk_sys),
      .rst_n    (rst_n),
      .clr      (accept),
      .load     (1'b0),
      .load_val ('0),
      .en       (state == ACCESS && !ack_hit),
      .expire   (tmo_expire)
   );

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         h_ready       <= 1'b1;
         h_rvalid      <= 1'b0;
         h_rdata       <= '0;
         h_err         <= 1'b0;
         p_req         <= '0;
         p_we          <= 1'b0;
         p_addr        <= '0;
         p_wdata       <= '0;
         sel_q         <= '0;
         stat_timeouts <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  h_ready <= 1'b0;
                  p_we    <= h_we;
                  p_addr  <= h_addr[OFFS_W-1:0];
                  p_wdata <= h_wdata;
                  sel_q   <= h_sel;
                  if (sel_ok) begin
                     p_req <= PORT0 << h_sel;
                     state <= ACCESS;
                  end else begin
                     h_rvalid <= 1'b1;
                     h_err    <= 1'b1;
                     h_rdata  <= '0;
                     state    <= RESP;
                  end
               end
            end
            ACCESS: begin
               // An ack in the final allowed cycle takes priority over the timeout.
               if (ack_hit) begin
                  p_req    <= '0;
                  h_rdata  <= p_we ? '0 : rd_slice;
                  h_err    <= 1'b0;
                  h_rvalid <= 1'b1;
                  state    <= RESP;
               end else if (tmo_expire) begin
                  p_req    <= '0;
                  h_rdata  <= '0;
                  h_err    <= 1'b1;
                  h_rvalid <= 1'b1;
                  if (stat_timeouts != '1)
                     stat_timeouts <= stat_timeouts + 1'b1;
                  state    <= RESP;
               end
            end
            RESP: begin
               h_rvalid <= 1'b0;
               h_ready  <= 1'b1;
               state    <= IDLE;
            end
            default: begin
               p_req    <= '0;
               h_rvalid <= 1'b0;
               h_ready  <= 1'b1;
               state    <= IDLE;
            end
         endcase
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_flapjack_periph_bus.sv
// Bench for flapjack_periph_bus: a 4-port instance with TIMEOUT=8 for the main traffic and a
// 3-port instance for the unmapped-select path.
module tb_flapjack_periph_bus;
   import flapjack_bus_pkg::*;

   localparam int DW  = 16;
   localparam int TMO = 8;

   // ---------------- clock / reset ----------------
   logic clk_sys = 1'b0;
   logic rst_n   = 1'b0;
   int   cyc     = 0;
   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   // 4-port instance
   logic        h_req = 1'b0, h_we = 1'b0;
   logic [15:0] h_addr = '0, h_wdata = '0;
   logic        h_ready, h_rvalid, h_err;
   logic [15:0] h_rdata;
   logic [3:0]  p_req;
   logic        p_we;
   logic [13:0] p_addr;
   logic [15:0] p_wdata;
   logic [3:0]  p_ack = '0;
   logic [63:0] p_rdata = '0;
   logic [7:0]  stat_timeouts;
   bus_state_t  dbg_state;

   // 3-port instance
   logic        h3_req = 1'b0, h3_we = 1'b0;
   logic [15:0] h3_addr = '0, h3_wdata = '0;
   logic        h3_ready, h3_rvalid, h3_err;
   logic [15:0] h3_rdata;
   logic [2:0]  p3_req;
   logic        p3_we;
   logic [13:0] p3_addr;
   logic [15:0] p3_wdata;
   logic [2:0]  p3_ack = '0;
   logic [47:0] p3_rdata = '0;
   logic [7:0]  stat3_timeouts;
   bus_state_t  dbg3_state;

   flapjack_periph_bus #(
      .NUM_PERIPH(4), .ADDR_W(16), .DATA_W(16), .SEL_W(2), .TIMEOUT(TMO)
   ) u_dut (
      .clk_sys(clk_sys), .rst_n(rst_n), .h_req(h_req), .h_we(h_we), .h_addr(h_addr),
      .h_wdata(h_wdata), .h_ready(h_ready), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
      .h_err(h_err), .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
      .p_ack(p_ack), .p_rdata(p_rdata), .stat_timeouts(stat_timeouts), .dbg_state(dbg_state)
   );

   flapjack_periph_bus #(
      .NUM_PERIPH(3), .ADDR_W(16), .DATA_W(16), .SEL_W(2), .TIMEOUT(TMO)
   ) u_dut3 (
      .clk_sys(clk_sys), .rst_n(rst_n), .h_req(h3_req), .h_we(h3_we), .h_addr(h3_addr),
      .h_wdata(h3_wdata), .h_ready(h3_ready), .h_rvalid(h3_rvalid), .h_rdata(h3_rdata),
      .h_err(h3_err), .p_req(p3_req), .p_we(p3_we), .p_addr(p3_addr), .p_wdata(p3_wdata),
      .p_ack(p3_ack), .p_rdata(p3_rdata), .stat_timeouts(stat3_timeouts), .dbg_state(dbg3_state)
   );

   // ---------------- scoreboard ----------------
   int n_cmp  = 0;
   int n_fail = 0;
   int rv_cyc = 0;
   logic [DW:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Completion monitor: every h_rvalid pulse must match the oldest expected {err, rdata}.
   always @(negedge clk_sys) begin : monitor
      logic [DW:0] e;
      if (rst_n && h_rvalid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rvalid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
         end else begin
            e = exp_q.pop_front();
            check("resp_err_rdata", {h_err, h_rdata}, e);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!h_ready && n < 20) begin
         tick();
         n++;
      end
      check("ready_wait", h_ready, 1);
   endtask

   task automatic do_access(input logic [15:0] addr, input logic we, input logic [15:0] wdata,
                            input int delay, input logic [3:0] stray, input logic [15:0] slice,
                            input logic [3:0] exp_preq, input logic [13:0] exp_paddr,
                            input logic [15:0] exp_rdata);
      logic [1:0] sel;
      sel = addr[15:14];
      wait_ready();
      h_req   = 1'b1;
      h_we    = we;
      h_addr  = addr;
      h_wdata = wdata;
      p_rdata = {$urandom, $urandom};
      p_rdata[sel*16 +: 16] = slice;
      exp_q.push_back({1'b0, exp_rdata});
      tick();
      // Scramble the host bus after acceptance: the fabric must work from its latches.
      h_req   = 1'b0;
      h_we    = 1'($urandom);
      h_addr  = 16'($urandom);
      h_wdata = 16'($urandom);
      check("preq", p_req, exp_preq);
      check("paddr", p_addr, exp_paddr);
      check("pwe", p_we, we);
      check("pwdata", p_wdata, wdata);
      check("ready_busy", h_ready, 0);
      check("state_access", dbg_state, ACCESS);
      for (int d = 0; d < delay; d++) begin
         p_ack = stray;
         tick();
         check("preq_hold", p_req, exp_preq);
         check("pwdata_hold", p_wdata, wdata);
         check("rvalid_early", h_rvalid, 0);
      end
      p_ack = exp_preq;
      tick();
      p_ack  = '0;
      rv_cyc = cyc;
      check("rvalid", h_rvalid, 1);
      check("preq_drop", p_req, 0);
      tick();
      check("rvalid_pulse", h_rvalid, 0);
      check("ready_idle", h_ready, 1);
      check("rdata_hold", h_rdata, exp_rdata);
   endtask

   task automatic do_timeout(input logic [15:0] addr, input logic [3:0] mask, input bit late_ack);
      int n = 0;
      wait_ready();
      h_req  = 1'b1;
      h_we   = 1'b0;
      h_addr = addr;
      exp_q.push_back({1'b1, 16'h0000});
      tick();
      h_req = 1'b0;
      check("tmo_preq", p_req, mask);
      while ((p_req & mask) != 0 && n < 50) begin
         n++;
         tick();
      end
      check("tmo_preq_cycles", n, TMO);
      check("tmo_rvalid", h_rvalid, 1);
      check("tmo_err", h_err, 1);
      check("tmo_rdata", h_rdata, 0);
      if (late_ack) begin
         p_ack = mask;
         tick();
         tick();
         p_ack = '0;
         check("late_ack_state", dbg_state, IDLE);
         check("late_ack_rvalid", h_rvalid, 0);
         check("late_ack_err_hold", h_err, 1);
      end else begin
         tick();
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [15:0] addr;
      logic        we;
      logic [15:0] wdata;
      int          delay;
      logic [3:0]  stray;
      logic [15:0] slice;
      logic [3:0]  exp_preq;
      logic [13:0] exp_paddr;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];
   int   rv_prev;

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got no end expected end before time limit");
      $fatal(1, "bench time limit");
   end

   initial begin
      vecs[0] = '{16'h4012, 1'b0, 16'h0000, 0, 4'b0000, 16'hBEEF, 4'b0010, 14'h0012, 16'hBEEF};
      vecs[1] = '{16'h0003, 1'b1, 16'h00A5, 5, 4'b0000, 16'h9999, 4'b0001, 14'h0003, 16'h0000};
      vecs[2] = '{16'hFFFF, 1'b0, 16'h0000, 2, 4'b0000, 16'h1234, 4'b1000, 14'h3FFF, 16'h1234};
      vecs[3] = '{16'h8000, 1'b0, 16'h0000, 7, 4'b0000, 16'h5A5A, 4'b0100, 14'h0000, 16'h5A5A};
      vecs[4] = '{16'hC100, 1'b1, 16'hFFFF, 1, 4'b0000, 16'h7777, 4'b1000, 14'h0100, 16'h0000};
      vecs[5] = '{16'h0040, 1'b0, 16'h0000, 2, 4'b1000, 16'hCAFE, 4'b0001, 14'h0040, 16'hCAFE};

      // Reset values while reset is held.
      #12;
      check("rst_ready", h_ready, 1);
      check("rst_rvalid", h_rvalid, 0);
      check("rst_rdata", h_rdata, 0);
      check("rst_err", h_err, 0);
      check("rst_preq", p_req, 0);
      check("rst_paddr", p_addr, 0);
      check("rst_stat", stat_timeouts, 0);
      check("rst_state", dbg_state, IDLE);
      @(negedge clk_sys);
      rst_n = 1'b1;
      tick();

      // Table-driven accesses: reads, writes, delayed acks, ack on the last allowed cycle,
      // stray ack on a non-selected port.
      for (int i = 0; i < 6; i++)
         do_access(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].delay, vecs[i].stray,
                   vecs[i].slice, vecs[i].exp_preq, vecs[i].exp_paddr, vecs[i].exp_rdata);

      // Back-to-back accesses with immediate acks: one completion every 3 cycles.
      do_access(16'h0001, 1'b0, 16'h0000, 0, 4'b0000, 16'h1111, 4'b0001, 14'h0001, 16'h1111);
      rv_prev = rv_cyc;
      for (int p = 1; p < 4; p++) begin
         do_access({p[1:0], 14'h0020}, 1'b0, 16'h0000, 0, 4'b0000, 16'h2000 + 16'(p),
                   4'b0001 << p, 14'h0020, 16'h2000 + 16'(p));
         check("b2b_spacing", rv_cyc - rv_prev, 3);
         rv_prev = rv_cyc;
      end

      // 3-port instance: a mapped access, then an unmapped select.
      h3_req   = 1'b1;
      h3_addr  = 16'h8004;
      p3_rdata = 48'({$urandom, $urandom});
      p3_rdata[47:32] = 16'h2222;
      tick();
      h3_req = 1'b0;
      check("np3_preq", p3_req, 3'b100);
      p3_ack = 3'b100;
      tick();
      p3_ack = '0;
      check("np3_rvalid", h3_rvalid, 1);
      check("np3_rdata", h3_rdata, 16'h2222);
      tick();
      h3_req  = 1'b1;
      h3_addr = 16'hC000;
      check("np3_ready", h3_ready, 1);
      tick();
      h3_req = 1'b0;
      check("badsel_rvalid", h3_rvalid, 1);
      check("badsel_err", h3_err, 1);
      check("badsel_rdata", h3_rdata, 0);
      check("badsel_preq", p3_req, 0);
      check("badsel_state", dbg3_state, RESP);
      tick();
      check("badsel_pulse", h3_rvalid, 0);
      check("badsel_ready", h3_ready, 1);
      check("badsel_err_hold", h3_err, 1);
      check("badsel_preq_idle", p3_req, 0);

      // Timeouts: first with a late ack, then up to and past saturation.
      do_timeout(16'h8000, 4'b0100, 1'b1);
      check("stat_one", stat_timeouts, 1);
      for (int i = 1; i < 255; i++)
         do_timeout(16'h8000, 4'b0100, 1'b0);
      check("stat_255", stat_timeouts, 255);
      for (int i = 0; i < 45; i++)
         do_timeout(16'h8000, 4'b0100, 1'b0);
      check("stat_sat", stat_timeouts, 255);

      // Error flag clears on the next good completion.
      do_access(16'h4005, 1'b0, 16'h0000, 0, 4'b0000, 16'h0F0F, 4'b0010, 14'h0005, 16'h0F0F);
      check("err_clear", h_err, 0);

      // Asynchronous reset in the middle of an access: dropped without completion.
      wait_ready();
      h_req  = 1'b1;
      h_addr = 16'h4001;
      tick();
      h_req = 1'b0;
      check("rstmid_preq_before", p_req, 4'b0010);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstmid_preq_async", p_req, 0);
      check("rstmid_rvalid", h_rvalid, 0);
      check("rstmid_stat", stat_timeouts, 0);
      check("rstmid_ready", h_ready, 1);
      repeat (2) @(posedge clk_sys);
      @(negedge clk_sys);
      rst_n = 1'b1;
      tick();
      check("rstmid_state", dbg_state, IDLE);
      check("rstmid_ready_after", h_ready, 1);
      tick();
      check("rstmid_no_rvalid", h_rvalid, 0);

      repeat (3) tick();
      check("queue_drain", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
